// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch/decode constants, opcodes and fetch FSM types.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    // addi x0,x0,0
    localparam logic [31:0] DEFAULT_NOP_INSTR = {25'd0, OPC_OP_IMM};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_skid_buffer.sv
// ============================================================================
// Module      : instr_skid_buffer
// Description : Output register plus one skid entry carrying {instruction, pc}.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_skid_buffer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_skid_valid
);

    fetch_entry_t r_out;
    fetch_entry_t r_skid;
    logic         r_out_valid;
    logic         r_skid_valid;
    fetch_entry_t w_push_entry;
    logic         w_consume;

    assign w_push_entry = '{instr: i_instr, pc: i_pc};
    assign w_consume    = r_out_valid & i_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out        <= '{instr: NOP_INSTR, pc: RESET_PC};
            r_skid_valid <= 1'b0;
            r_skid       <= '{instr: NOP_INSTR, pc: RESET_PC};
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_out.instr  <= NOP_INSTR;
            r_skid_valid <= 1'b0;
        end else if (w_consume) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_skid_valid <= i_push;
                if (i_push) begin
                    r_skid <= w_push_entry;
                end
            end else if (i_push) begin
                r_out <= w_push_entry;
            end else begin
                r_out_valid <= 1'b0;
                r_out.instr <= NOP_INSTR;
            end
        end else if (i_push) begin
            // Held output: the arriving word parks in the skid entry
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out       <= w_push_entry;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid       <= w_push_entry;
            end
        end
    end

    assign o_valid      = r_out_valid;
    assign o_instr      = r_out.instr;
    assign o_pc         = r_out.pc;
    assign o_skid_valid = r_skid_valid;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC owner and single-outstanding imem fetcher with redirect.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instr_valid
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;
    logic         r_drop;

    logic         w_skid_valid;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_gnt;
    logic         w_push;

    assign w_redirect = branch_taken & instr_valid & ~stall;
    assign w_target   = branch_target & 32'hFFFF_FFFC;
    assign imem_req   = (r_state == REQ) & ~w_skid_valid;
    assign imem_addr  = r_fetch_pc;
    assign w_gnt      = imem_req & imem_gnt;
    // A response landing together with a redirect is wrong-path as well
    assign w_push     = (r_state == WAIT) & imem_rvalid & ~r_drop & ~w_redirect;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_drop     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                end
                REQ: begin
                    if (w_gnt) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= WAIT;
                        r_drop     <= w_redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= REQ;
                        r_drop  <= 1'b0;
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end
        end
    end

    instr_skid_buffer #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk          (clk),
        .rst_n        (resetn),
        .i_push       (w_push),
        .i_instr      (imem_rdata),
        .i_pc         (r_req_pc),
        .i_pop        (~stall),
        .i_flush      (w_redirect),
        .o_valid      (instr_valid),
        .o_instr      (instruction),
        .o_pc         (pc),
        .o_skid_valid (w_skid_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Scoreboard bench for instruction_fetch_unit (memory returns addr+0x100).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

    logic        clk           = 1'b0;
    logic        resetn        = 1'b0;
    logic        stall         = 1'b0;
    logic        branch_taken  = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid   = 1'b0;
    logic [31:0] imem_rdata    = 32'd0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;

    logic        gnt_en   = 1'b1;
    logic        rsp_hold = 1'b0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign imem_gnt = imem_req & gnt_en;

    instruction_fetch_unit dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc            (pc),
        .instr_valid   (instr_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic wait_valid_pc(input logic [31:0] want);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(instr_valid && pc == want) && n < 40);
        total++;
        if (!(instr_valid && pc == want)) begin
            bad++;
            $display("FAIL wait_pc: got valid=%0b pc=%h want pc=%h", instr_valid, pc, want);
        end
    endtask

    // Memory: one-cycle response latency unless held
    initial forever begin
        @(negedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (pend && !rsp_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr + 32'h100;
            pend        = 1'b0;
        end
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
        end
    end

    // Monitor: every consumed instruction is checked against the queue
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        #2;
        if (resetn && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got pc=%h instr=%h want none", pc, instruction);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e);
                check("sb_instr", instruction, e + 32'h100);
            end
        end
        #1;
        if (resetn) begin
            assert (!branch_taken || (instr_valid && !stall))
                else $error("branch_taken raised while not qualified");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_pc", pc, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        // Straight-line fetch
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        resetn = 1'b1;
        check("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'd0);
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            check("alt_valid", 32'(instr_valid), (c % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("pc8", pc, 32'h8);

        // Stall six cycles on pc=8
        stall = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h8);
            check("stall_valid", 32'(instr_valid), 32'd1);
            if (k >= 2) check("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        exp_q.push_back(32'hC);
        @(negedge clk);
        check("skid_pc", pc, 32'hC);
        check("skid_valid", 32'(instr_valid), 32'd1);

        // Redirect while WAIT on 0x10 with the response held back
        stall    = 1'b1;
        rsp_hold = 1'b1;
        exp_q.push_back(32'h40);
        @(negedge clk);
        check("wait_req", 32'(imem_req), 32'd0);
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        branch_taken = 1'b0;
        rsp_hold     = 1'b0;
        check("redir_bubble", 32'(instr_valid), 32'd0);
        wait_valid_pc(32'h40);

        // Redirect to 0x43 in the same cycle as rvalid
        stall = 1'b1;
        exp_q.push_back(32'h40);
        @(negedge clk);
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        @(negedge clk);
        branch_taken = 1'b0;
        check("same_bubble", 32'(instr_valid), 32'd0);
        check("same_req", 32'(imem_req), 32'd1);
        check("same_addr", imem_addr, 32'h40);
        wait_valid_pc(32'h40);

        // Reset pulse mid-WAIT, stale response lands in IDLE
        rsp_hold = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_instr", instruction, 32'h0000_0013);
        check("mid_rst_pc", pc, 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        exp_q.push_back(32'h0);
        resetn   = 1'b1;
        rsp_hold = 1'b0;
        check("rel_idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("stale_valid", 32'(instr_valid), 32'd0);
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'd0);
        wait_valid_pc(32'h0);

        // Redirect in REQ with gnt to the top word, then wrap
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        @(negedge clk);
        branch_taken = 1'b0;
        check("top_bubble", 32'(instr_valid), 32'd0);
        wait_valid_pc(32'hFFFF_FFFC);
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'd0);
        wait_valid_pc(32'h0);
        stall = 1'b1;
        check("wrap_instr", instruction, 32'h100);
        repeat (3) @(negedge clk);
        check("final_pc", pc, 32'h0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_left: got %0d entries want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
